// File: rtl/myproject_dense_acc_26s_16s.sv
// Dense-layer accumulator for the 10s x 16s -> 26s multiplier stream.
//
// Sums N_IN signed products plus a per-neuron bias. The bias is given at output scale and is
// aligned to the product scale by shifting it left by SHIFT. The sum is then rescaled by an
// arithmetic right shift of SHIFT bits, rounding half toward +inf, and saturated to OUT_WIDTH
// bits. One result is emitted per neuron over a valid/ready handshake.
//
// Ports:
//   ap_clk    clock, rising edge
//   ap_rst    synchronous active-high reset
//   prod_V    signed product input (PROD_WIDTH)
//   prod_vld  product valid
//   prod_rdy  product ready; low while a result is pending or during reset
//   bias_V    signed bias at output scale, sampled with the first product of a neuron
//   out_V     rounded, saturated result (OUT_WIDTH)
//   out_vld   result valid
//   out_rdy   downstream ready
//   ovf       result was saturated; qualified by out_vld
module myproject_dense_acc_26s_16s #(
  parameter int unsigned PROD_WIDTH = 26,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned N_IN       = 4,
  parameter int unsigned SHIFT      = 10
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic signed [PROD_WIDTH-1:0] prod_V,
  input  logic                        prod_vld,
  output logic                        prod_rdy,
  input  logic signed [OUT_WIDTH-1:0]  bias_V,
  output logic signed [OUT_WIDTH-1:0]  out_V,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic                        ovf
);

  // Parameter sanity: the accumulator must hold N_IN full-scale products with headroom.
  if (ACC_WIDTH < PROD_WIDTH + $clog2(N_IN) + 2) begin : g_acc_width_check
    $error("ACC_WIDTH too small for PROD_WIDTH and N_IN");
  end
  if (ACC_WIDTH <= OUT_WIDTH) begin : g_out_width_check
    $error("ACC_WIDTH must exceed OUT_WIDTH");
  end
  if (N_IN < 1) begin : g_n_in_check
    $error("N_IN must be at least 1");
  end

  localparam int unsigned CntW = $clog2(N_IN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(N_IN - 1);

  // Rounding constant: half an output LSB expressed at accumulator scale.
  localparam int unsigned RndPos = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] RndAdd =
      (SHIFT > 0) ? ((ACC_WIDTH + 1)'(1) << RndPos) : '0;

  // Output range limits, sign-extended to the rounding width for comparison.
  localparam logic signed [ACC_WIDTH:0] OutMax =
      {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OutMin =
      {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OutMaxN = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OutMinN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic                         ovf_q, ovf_d;

  logic                         prod_beat;
  logic                         out_beat;
  logic                         last_beat;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  bias_scaled;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [ACC_WIDTH:0]    rnd_sum;
  logic signed [ACC_WIDTH:0]    rnd_val;
  logic signed [OUT_WIDTH-1:0]  res_val;
  logic                         res_sat;

  assign prod_rdy  = (state_q != StOut) && !ap_rst;
  assign out_vld   = (state_q == StOut);
  assign out_V     = out_q;
  assign ovf       = ovf_q;
  assign prod_beat = prod_vld && prod_rdy;
  assign out_beat  = out_vld && out_rdy;

  assign prod_ext    = {{(ACC_WIDTH - PROD_WIDTH){prod_V[PROD_WIDTH-1]}}, prod_V};
  assign bias_scaled = {{(ACC_WIDTH - OUT_WIDTH){bias_V[OUT_WIDTH-1]}}, bias_V} <<< SHIFT;

  // The first beat of a neuron seeds the sum with the aligned bias instead of the old acc.
  always_comb begin
    acc_next = acc_q + prod_ext;
    if (state_q == StIdle) begin
      acc_next = bias_scaled + prod_ext;
    end
  end

  always_comb begin
    last_beat = (cnt_q == CntLast);
    if (state_q == StIdle) begin
      last_beat = (N_IN == 1);
    end
  end

  // Round half toward +inf, then saturate. One extra bit keeps the rounding add from wrapping.
  always_comb begin
    rnd_sum = {acc_next[ACC_WIDTH-1], acc_next} + RndAdd;
    rnd_val = rnd_sum >>> SHIFT;
    res_sat = 1'b0;
    res_val = rnd_val[OUT_WIDTH-1:0];
    if (rnd_val > OutMax) begin
      res_val = OutMaxN;
      res_sat = 1'b1;
    end else if (rnd_val < OutMin) begin
      res_val = OutMinN;
      res_sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (prod_beat) begin
          acc_d   = acc_next;
          cnt_d   = CntW'(1);
          state_d = last_beat ? StOut : StAcc;
        end
      end
      StAcc: begin
        if (prod_beat) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CntW'(1);
          if (last_beat) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (out_beat) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Result is captured from the sum including the final product, not from acc_q.
    if (prod_beat && last_beat) begin
      out_d = res_val;
      ovf_d = res_sat;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_myproject_dense_acc_26s_16s.sv
// Bench for myproject_dense_acc_26s_16s: directed cases with literal results followed by
// randomized traffic, with a per-neuron arithmetic model checked on every cycle.
module tb_myproject_dense_acc_26s_16s;

  localparam int unsigned PW    = 26;
  localparam int unsigned AW    = 32;
  localparam int unsigned OW    = 16;
  localparam int unsigned NIN   = 4;
  localparam int unsigned SHIFT = 10;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst = 1'b1;
  logic signed [PW-1:0] prod_V = '0;
  logic                 prod_vld = 1'b0;
  logic                 prod_rdy;
  logic signed [OW-1:0] bias_V = '0;
  logic signed [OW-1:0] out_V;
  logic                 out_vld;
  logic                 out_rdy = 1'b0;
  logic                 ovf;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 ap_clk = ~ap_clk;

  myproject_dense_acc_26s_16s #(
    .PROD_WIDTH(PW),
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW),
    .N_IN      (NIN),
    .SHIFT     (SHIFT)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .prod_V  (prod_V),
    .prod_vld(prod_vld),
    .prod_rdy(prod_rdy),
    .bias_V  (bias_V),
    .out_V   (out_V),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .ovf     (ovf)
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: result = floor((sum + half) / 2^SHIFT), clamped to the output range.
  function automatic void round_sat(input longint a, output logic signed [OW-1:0] o,
                                    output bit v);
    longint t, q, mx, mn, scale;
    scale = longint'(1) << SHIFT;
    t  = a + scale / 2;
    q  = t / scale;
    if (t < 0 && (t % scale) != 0) q = q - 1;
    mx = (longint'(1) << (OW - 1)) - 1;
    mn = -(longint'(1) << (OW - 1));
    v  = 1'b0;
    if (q > mx) begin
      q = mx;
      v = 1'b1;
    end else if (q < mn) begin
      q = mn;
      v = 1'b1;
    end
    o = OW'(q);
  endfunction

  bit                   exp_pend = 1'b0;
  logic signed [OW-1:0] exp_out = '0;
  bit                   exp_ovf = 1'b0;
  longint               m_acc = 0;
  int                   m_cnt = 0;

  // Model update: a neuron is a list of accepted products; the first carries the bias.
  always @(posedge ap_clk) begin : model
    longint               a;
    logic signed [OW-1:0] o;
    bit                   v;
    if (ap_rst) begin
      exp_pend <= 1'b0;
      m_cnt    <= 0;
      m_acc    <= 0;
      exp_out  <= '0;
      exp_ovf  <= 1'b0;
    end else if (exp_pend) begin
      if (out_rdy) exp_pend <= 1'b0;
    end else if (prod_vld) begin
      if (m_cnt == 0) a = longint'(bias_V) * (longint'(1) << SHIFT) + longint'(prod_V);
      else a = m_acc + longint'(prod_V);
      if (m_cnt + 1 == NIN) begin
        round_sat(a, o, v);
        exp_out  <= o;
        exp_ovf  <= v;
        exp_pend <= 1'b1;
        m_cnt    <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      m_acc <= a;
    end
  end

  always @(negedge ap_clk) begin
    if (cmp_on) begin
      chk("cyc_prod_rdy", prod_rdy, !exp_pend && !ap_rst);
      chk("cyc_out_vld", out_vld, exp_pend);
      if (exp_pend) begin
        chk("cyc_out_V", out_V, exp_out);
        chk("cyc_ovf", ovf, exp_ovf);
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic beat(input logic signed [PW-1:0] p, input logic signed [OW-1:0] b);
    int n;
    prod_V   = p;
    bias_V   = b;
    prod_vld = 1'b1;
    n = 0;
    @(negedge ap_clk);
    while (!prod_rdy && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    if (!prod_rdy) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: prod_rdy stayed %0d, required 1", prod_rdy);
    end
    @(posedge ap_clk);
    #1;
    prod_vld = 1'b0;
  endtask

  // Sends one neuron with random gaps of 0..maxgap cycles; checks the result one cycle after
  // the final beat.
  task automatic neuron(input string nm, input logic signed [OW-1:0] b,
                        input logic signed [PW-1:0] p0, input logic signed [PW-1:0] p1,
                        input logic signed [PW-1:0] p2, input logic signed [PW-1:0] p3,
                        input int maxgap, input logic signed [OW-1:0] eo, input bit eovf);
    logic signed [PW-1:0] p[4];
    p = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, maxgap)) step();
      beat(p[i], b);
    end
    chk({nm, "_vld"}, out_vld, 1);
    chk({nm, "_out"}, out_V, eo);
    chk({nm, "_ovf"}, ovf, eovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst = 1'b1;
    repeat (3) step();
    chk("rst_out_V", out_V, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_ovf", ovf, 0);
    ap_rst = 1'b0;
    #1;
    chk("rst_prod_rdy", prod_rdy, 1);
    cmp_on  = 1'b1;
    out_rdy = 1'b1;

    neuron("basic", 0, 1024, 2048, -1024, 512, 0, 3, 0);
    step();
    chk("basic_idle", out_vld, 0);
    neuron("neg_half", 0, -384, -384, -384, -384, 0, -1, 0);
    step();
    neuron("bias5", 5, 0, 0, 0, -512, 0, 5, 0);
    step();
    neuron("sat_hi", 0, 16777216, 16777216, 16777216, 16777216, 0, 32767, 1);
    step();
    neuron("sat_lo", 0, -33554432, -33554432, -33554432, -33554432, 0, -32768, 1);
    step();

    // Backpressure: result held, products refused.
    out_rdy = 1'b0;
    neuron("bp_first", 0, 2048, 2048, 2048, 2048, 0, 8, 0);
    prod_vld = 1'b1;
    prod_V   = 26'sd12345;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_vld", out_vld, 1);
      chk("bp_out", out_V, 8);
      chk("bp_rdy", prod_rdy, 0);
    end
    prod_vld = 1'b0;
    out_rdy  = 1'b1;
    step();
    chk("bp_drain", out_vld, 0);
    neuron("bp_next", 0, 1024, 1024, 1024, 1024, 0, 4, 0);
    step();

    neuron("bubbles", 1, 1024, 1024, 1024, 1024, 3, 5, 0);
    step();

    // Reset mid-sum.
    beat(2048, 0);
    beat(2048, 0);
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    chk("rstmid_out", out_V, 0);
    chk("rstmid_vld", out_vld, 0);
    chk("rstmid_ovf", ovf, 0);
    neuron("rstmid_next", 0, 1024, 1024, 1024, 1024, 0, 4, 0);
    step();

    // Reset with a result pending.
    out_rdy = 1'b0;
    neuron("rstpend", 0, 16777216, 16777216, 16777216, 16777216, 0, 32767, 1);
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    chk("rstpend_vld", out_vld, 0);
    chk("rstpend_ovf", ovf, 0);
    out_rdy = 1'b1;
    neuron("rstpend_next", 0, 1024, 1024, 1024, 1024, 0, 4, 0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      prod_vld = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) prod_V = PW'($urandom);
      else prod_V = PW'(int'($urandom_range(0, 8191)) - 4096);
      bias_V  = OW'($urandom);
      out_rdy = ($urandom_range(0, 9) < 6);
      ap_rst  = ($urandom_range(0, 199) == 0);
      step();
    end
    ap_rst   = 1'b0;
    prod_vld = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
